uart_rx_buffer_ctrl: RTL
========================

// Module: uart_rx_buffer_ctrl
// PURPOSE
//  Sequencer and buffer sitting between uart_rx and the consumer logic.
//  - Detects uart_rx's DV flag, captures Data into a small FIFO and drives CLR_DV back to uart_rx.
//  - Presents buffered bytes on a valid/ready stream.
//  - Counts nothing lost silently: a full FIFO raises a sticky overflow flag.
//  Frees the consumer from servicing uart_rx within one frame time.
// PARAMETERS
//  bits       8  width of one received byte; must equal uart_rx bits
//  depth_exp  3  log2 of FIFO depth
//  depth      8  FIFO entries; depth = 2^depth_exp must hold
// PORTS
//  CLK        in   1            system clock; all logic on rising edge
//  RST        in   1            synchronous reset, active-low (0 at posedge CLK resets)
//  RX_DATA    in   bits         uart_rx Data; stable while RX_DV high
//  RX_DV      in   1            uart_rx DV (generated on baudClk, asynchronous to CLK)
//  RX_CLR_DV  out  1            to uart_rx CLR_DV; level, held until RX_DV seen low
//  OUT_DATA   out  bits         head-of-FIFO byte (first-word fall-through)
//  OUT_VALID  out  1            FIFO not empty
//  OUT_READY  in   1            consumer accepts; pop when OUT_VALID && OUT_READY
//  COUNT      out  depth_exp+1  bytes held, 0..depth
//  OVF        out  1            sticky: a byte was dropped because FIFO was full
//  CLR_OVF    in   1            clears OVF
// BEHAVIOUR
//  Reset (RST=0):
//    - FSM -> IDLE; sync flops, pointers, COUNT, OVF, RX_CLR_DV all 0.
//    - OUT_VALID 0; OUT_DATA don't-care.
//    - Buffered bytes are discarded.
//  RX_DV synchronizer: 2 flops (dv_s1, dv_s2); the FSM uses dv_s2 only.
//    RX_DATA is sampled directly; it is stable by the time dv_s2 rises.
//  FSM, 2 states:
//    IDLE : dv_s2=1 -> capture RX_DATA (push, or drop+OVF) and go to CLEAR; RX_CLR_DV<=1
//    CLEAR: RX_CLR_DV held 1; dv_s2=0 -> IDLE, RX_CLR_DV<=0
//           (no capture in CLEAR, so each frame is taken exactly once)
//  Latency, with RX_DV first high at edge 0:
//    - dv_s2 high after edge 1.
//    - Push at edge 2; OUT_VALID (if previously empty) and RX_CLR_DV high after edge 2.
//    - RX_CLR_DV falls 2 edges after RX_DV is first sampled low (synchronizer latency + FSM step).
//  FIFO: wr/rd pointers depth_exp+1 bits wide, wrap modulo 2*depth; COUNT = wr - rd.
//  Push allowed when COUNT<depth OR a pop occurs in the same cycle.
//    Simultaneous push+pop keeps COUNT; pop from empty is impossible (OUT_VALID=0).
//  Full and no pop at capture:
//    - Byte dropped, OVF<=1; COUNT and FIFO contents unchanged.
//    - RX_CLR_DV still asserted, so uart_rx is always released.
//  OVF: CLR_OVF=1 clears it; a new overflow in the same cycle wins (OVF stays 1).
//  Reset mid-CLEAR: RX_CLR_DV drops next edge. If RX_DV is still high after reset, that byte is recaptured.
// STRUCTURE
//  - FSM state encodings (ST_IDLE=1'b0, ST_CLEAR=1'b1) go in the shared uart_defs.vh include.
//  - One sub-module: sync_fifo #(.bits, .depth_exp) holding mem, pointers, COUNT, push/pop;
//    this top holds the synchronizer, FSM and OVF.
// TESTING
//  1. Hold RST=0 2 cycles with RX_DV=1 -> RX_CLR_DV=0, OUT_VALID=0, COUNT=0, OVF=0.
//  2. RX_DATA=0xA5, RX_DV high at edge 0 -> after edge 2 OUT_VALID=1, OUT_DATA=0xA5, COUNT=1, RX_CLR_DV=1;
//     drop RX_DV -> RX_CLR_DV=0 two edges later; no second push.
//  3. OUT_READY=0, send 0x01..0x08 -> COUNT=8; send 0x09 -> OVF=1, COUNT=8, RX_CLR_DV still pulses;
//     then drain -> 0x01..0x08 in order.
//  4. FIFO full, OUT_READY=1 in the capture cycle of 0x55 -> byte accepted, COUNT stays 8, OVF=0;
//     0x55 emerges last.
//  5. OVF=1, CLR_OVF=1 in the same cycle as a new full-drop -> OVF stays 1;
//     CLR_OVF alone next cycle -> OVF=0.
//  6. RST=0 for 1 cycle while in CLEAR with COUNT=3 -> RX_CLR_DV=0, COUNT=0, OUT_VALID=0;
//     RX_DV still high -> byte recaptured, COUNT=1.

Source files
------------

// File: rtl/uart_rx_buffer_ctrl_pkg.sv
// Shared types for the uart_rx buffer controller: handshake FSM encoding and default sizes.
package uart_rx_buffer_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rx_state_e;

  localparam int unsigned BITS_DEFAULT      = 8;
  localparam int unsigned DEPTH_EXP_DEFAULT = 3;

endpackage

// File: rtl/uart_rx_buffer_ctrl_sync_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int unsigned bits      = 8,
  parameter int unsigned depth_exp = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [bits-1:0]      data_i,
  output logic [bits-1:0]      data_o,
  output logic [depth_exp:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned depth = 2 ** depth_exp;

  logic [bits-1:0]    mem_q [depth];
  logic [depth_exp:0] wr_q, wr_d;
  logic [depth_exp:0] rd_q, rd_d;
  logic               wr_en;
  logic               rd_en;

  // Count never exceeds depth, so its top bit alone flags full.
  assign count_o = wr_q - rd_q;
  assign full_o  = count_o[depth_exp];
  assign empty_o = (wr_q == rd_q);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[depth_exp-1:0]];

  always_comb begin
    wr_d = wr_q + {{depth_exp{1'b0}}, wr_en};
    rd_d = rd_q + {{depth_exp{1'b0}}, rd_en};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[depth_exp-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Takes each uart_rx frame exactly once via a DV/CLR_DV handshake, buffers it in a
// FIFO and offers it on a valid/ready stream; dropped bytes raise a sticky OVF.
module uart_rx_buffer_ctrl #(
  parameter int unsigned bits      = uart_rx_buffer_ctrl_pkg::BITS_DEFAULT,
  parameter int unsigned depth_exp = uart_rx_buffer_ctrl_pkg::DEPTH_EXP_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [bits-1:0]      RX_DATA,
  input  logic                 RX_DV,
  output logic                 RX_CLR_DV,
  output logic [bits-1:0]      OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [depth_exp:0]   COUNT,
  output logic                 OVF,
  input  logic                 CLR_OVF
);

  import uart_rx_buffer_ctrl_pkg::*;

  logic      dv_s1_q, dv_s2_q;
  rx_state_e state_q;
  logic      clr_dv_q;
  logic      ovf_q, ovf_d;
  logic      capture, pop, drop;
  logic      fifo_full, fifo_empty;

  assign capture = (state_q == ST_IDLE) && dv_s2_q;
  assign pop     = OUT_VALID && OUT_READY;
  assign drop    = capture && fifo_full && !pop;

  // RX_DV comes from the baud clock domain; only dv_s2_q is trusted.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dv_s1_q <= 1'b0;
      dv_s2_q <= 1'b0;
    end else begin
      dv_s1_q <= RX_DV;
      dv_s2_q <= dv_s1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      clr_dv_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dv_s2_q) begin
            state_q  <= ST_CLEAR;
            clr_dv_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!dv_s2_q) begin
            state_q  <= ST_IDLE;
            clr_dv_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          clr_dv_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: defaulting ovf_d first keeps this block free of inferred latches.
  always_comb begin
    ovf_d = ovf_q;
    if (CLR_OVF) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  sync_fifo #(
    .bits      (bits),
    .depth_exp (depth_exp)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (capture),
    .pop_i   (pop),
    .data_i  (RX_DATA),
    .data_o  (OUT_DATA),
    .count_o (COUNT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign OUT_VALID = !fifo_empty;
  assign RX_CLR_DV = clr_dv_q;
  assign OVF       = ovf_q;

endmodule
